// File: rtl/bv8_back_basis_pipe.sv
// Tower-field to AES polynomial basis back map for a composite-field S-box.
// Forward beats add the S-box affine map; inverse beats are a plain basis change.
module bv8_back_basis_pipe #(
  parameter int NUM_STAGES = 2
) (
  input  logic       in_clk,
  input  logic       in_rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_z,
  input  logic       in_inv,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_s,
  output logic       out_inv,
  output logic [1:0] out_count
);

  // GF(2^4) mod x^4+x+1
  function automatic logic [3:0] gf16_mul(
    input logic [3:0] a,
    input logic [3:0] b
  );
    logic [3:0] r;
    logic [3:0] t;
    r = '0;
    t = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) r = r ^ t;
      t = {t[2:0], 1'b0} ^ {2'b00, t[3], t[3]};
    end
    return r;
  endfunction

  function automatic logic [3:0] tow_lambda();
    logic [3:0] lam;
    logic       found;
    logic       hit;
    lam   = '0;
    found = 1'b0;
    for (int c = 1; c < 16; c++) begin
      hit = 1'b0;
      for (int w = 0; w < 16; w++) begin
        if ((gf16_mul(4'(w), 4'(w)) ^ 4'(w)) == 4'(c))
          hit = 1'b1;
      end
      if (!found && !hit) begin
        lam   = 4'(c);
        found = 1'b1;
      end
    end
    return lam;
  endfunction

  // {h,l} = h*y + l with y^2 = y + lam
  function automatic logic [7:0] tow_mul(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [3:0] lam
  );
    logic [3:0] hh;
    logic [3:0] h;
    logic [3:0] l;
    hh = gf16_mul(a[7:4], b[7:4]);
    h  = hh ^ gf16_mul(a[7:4], b[3:0])
            ^ gf16_mul(a[3:0], b[7:4]);
    l  = gf16_mul(hh, lam) ^ gf16_mul(a[3:0], b[3:0]);
    return {h, l};
  endfunction

  // Columns g^i, g = smallest tower root of x^8+x^4+x^3+x+1
  function automatic logic [63:0] mk_m(input logic [3:0] lam);
    logic [7:0]  g2;
    logic [7:0]  g3;
    logic [7:0]  g4;
    logic [7:0]  g8;
    logic [7:0]  root;
    logic [7:0]  pw;
    logic [63:0] m;
    logic        found;
    root  = 8'h02;
    found = 1'b0;
    for (int c = 2; c < 256; c++) begin
      g2 = tow_mul(8'(c), 8'(c), lam);
      g3 = tow_mul(g2, 8'(c), lam);
      g4 = tow_mul(g2, g2, lam);
      g8 = tow_mul(g4, g4, lam);
      if (!found && (g8 ^ g4 ^ g3 ^ 8'(c) ^ 8'h01) == 8'h00) begin
        root  = 8'(c);
        found = 1'b1;
      end
    end
    m  = '0;
    pw = 8'h01;
    for (int i = 0; i < 8; i++) begin
      m[8*i +: 8] = pw;
      pw = tow_mul(pw, root, lam);
    end
    return m;
  endfunction

  function automatic logic [7:0] lin(
    input logic [63:0] c,
    input logic [7:0]  x
  );
    logic [7:0] r;
    r = '0;
    for (int j = 0; j < 8; j++) begin
      if (x[j]) r = r ^ c[8*j +: 8];
    end
    return r;
  endfunction

  function automatic logic [63:0] mk_minv(input logic [63:0] m);
    logic [63:0] r;
    r = '0;
    for (int j = 0; j < 8; j++) begin
      for (int a = 0; a < 256; a++) begin
        if (lin(m, 8'(a)) == (8'h01 << j))
          r[8*j +: 8] = 8'(a);
      end
    end
    return r;
  endfunction

  function automatic logic [7:0] aff_lin(input logic [7:0] x);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]}
             ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]};
  endfunction

  function automatic logic [63:0] mk_bf(input logic [63:0] minv);
    logic [63:0] r;
    r = '0;
    for (int j = 0; j < 8; j++) begin
      r[8*j +: 8] = aff_lin(minv[8*j +: 8]);
    end
    return r;
  endfunction

  localparam logic [3:0]  LAM    = tow_lambda();
  localparam logic [63:0] M_COLS = mk_m(LAM);
  localparam logic [63:0] BB     = mk_minv(M_COLS);
  localparam logic [63:0] BF     = mk_bf(BB);

  // Partial sums over each nibble of z: {hi, lo}
  function automatic logic [15:0] split(
    input logic [63:0] c,
    input logic [7:0]  z
  );
    logic [7:0] lo;
    logic [7:0] hi;
    lo = '0;
    hi = '0;
    for (int j = 0; j < 4; j++) begin
      if (z[j])     lo = lo ^ c[8*j +: 8];
      if (z[j + 4]) hi = hi ^ c[8*(j + 4) +: 8];
    end
    return {hi, lo};
  endfunction

  function automatic logic [7:0] fin(
    input logic [15:0] p,
    input logic        tag
  );
    return p[15:8] ^ p[7:0] ^ (tag ? 8'h00 : 8'h63);
  endfunction

  logic       in_fire;
  logic       out_fire;
  logic [7:0] s_o;
  logic       t_o;
  logic [1:0] cnt_q;
  logic [1:0] cnt_d;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  generate
    if (NUM_STAGES == 2) begin : g_two
      logic        v1_q, v1_d, t1_q, t1_d;
      logic        v2_q, v2_d, t2_q, t2_d;
      logic [15:0] p1_q, p1_d;
      logic [7:0]  s2_q, s2_d;
      logic        rdy2;
      logic        mv1;

      assign rdy2      = !v2_q || out_ready;
      assign mv1       = v1_q && rdy2;
      assign in_ready  = in_rst_n && (!v1_q || rdy2);
      assign out_valid = v2_q;
      assign s_o       = s2_q;
      assign t_o       = t2_q;

      always_comb begin
        v1_d = v1_q;
        t1_d = t1_q;
        p1_d = p1_q;
        v2_d = v2_q;
        t2_d = t2_q;
        s2_d = s2_q;
        if (out_fire) v2_d = 1'b0;
        if (mv1) begin
          v1_d = 1'b0;
          v2_d = 1'b1;
          t2_d = t1_q;
          s2_d = fin(p1_q, t1_q);
        end
        if (in_fire) begin
          v1_d = 1'b1;
          t1_d = in_inv;
          p1_d = split(in_inv ? BB : BF, in_z);
        end
      end

      always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
          v1_q <= 1'b0;
          v2_q <= 1'b0;
        end else begin
          v1_q <= v1_d;
          v2_q <= v2_d;
        end
      end

      always_ff @(posedge in_clk) begin
        t1_q <= t1_d;
        p1_q <= p1_d;
        t2_q <= t2_d;
        s2_q <= s2_d;
      end
    end else if (NUM_STAGES == 1) begin : g_one
      logic       v1_q, v1_d, t1_q, t1_d;
      logic [7:0] s1_q, s1_d;

      assign in_ready  = in_rst_n && (!v1_q || out_ready);
      assign out_valid = v1_q;
      assign s_o       = s1_q;
      assign t_o       = t1_q;

      always_comb begin
        v1_d = v1_q;
        t1_d = t1_q;
        s1_d = s1_q;
        if (out_fire) v1_d = 1'b0;
        if (in_fire) begin
          v1_d = 1'b1;
          t1_d = in_inv;
          s1_d = fin(split(in_inv ? BB : BF, in_z), in_inv);
        end
      end

      always_ff @(posedge in_clk) begin
        if (!in_rst_n) v1_q <= 1'b0;
        else           v1_q <= v1_d;
      end

      always_ff @(posedge in_clk) begin
        t1_q <= t1_d;
        s1_q <= s1_d;
      end
    end else begin : g_bad
      $error("NUM_STAGES must be 1 or 2");
    end
  endgenerate

  always_comb begin
    cnt_d = cnt_q;
    if (in_fire && !out_fire)
      cnt_d = cnt_q + 2'd1;
    else if (out_fire && !in_fire)
      cnt_d = cnt_q - 2'd1;
  end

  always_ff @(posedge in_clk) begin
    if (!in_rst_n) cnt_q <= 2'd0;
    else           cnt_q <= cnt_d;
  end

  assign out_count = cnt_q;
  assign out_s     = out_valid ? s_o : 8'h00;
  assign out_inv   = out_valid && t_o;

endmodule

// File: tb/tb_bv8_back_basis_pipe.sv
// Bench for bv8_back_basis_pipe: tower-basis stimulus from a reference
// inverter, results checked against a standard-basis AES S-box model.
module tb_bv8_back_basis_pipe;
  localparam int NS = 2;

  logic       clk;
  logic       in_rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_z;
  logic       in_inv;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_s;
  logic       out_inv;
  logic [1:0] out_count;

  bv8_back_basis_pipe #(.NUM_STAGES(NS)) dut (
    .in_clk   (clk),
    .in_rst_n (in_rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_z     (in_z),
    .in_inv   (in_inv),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_s    (out_s),
    .out_inv  (out_inv),
    .out_count(out_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [7:0] s;
    logic       inv;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic       inv;
    logic [7:0] exp;
  } vec_t;

  int         n_chk;
  int         n_pass;
  exp_t       q[$];
  logic [7:0] sbox [256];
  logic [7:0] isbox [256];
  logic [7:0] tinv [256];
  logic [3:0] lam;
  logic [7:0] root;
  logic       sm_rdy;
  logic       sm_ov;
  logic [7:0] sm_os;
  logic [1:0] sm_cnt;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  function automatic logic [7:0] aes_mul(input logic [7:0] a,
                                         input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] t;
    r = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r ^= t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1B : 8'h00);
    end
    return r;
  endfunction

  function automatic logic [3:0] b16_mul(input logic [3:0] a,
                                         input logic [3:0] b);
    logic [6:0] p;
    p = '0;
    for (int i = 0; i < 4; i++)
      if (b[i]) p ^= 7'(a) << i;
    for (int i = 6; i >= 4; i--)
      if (p[i]) p ^= 7'h13 << (i - 4);
    return p[3:0];
  endfunction

  function automatic logic [7:0] t_mul(input logic [7:0] a,
                                       input logic [7:0] b);
    logic [3:0] hh;
    logic [3:0] h;
    logic [3:0] l;
    hh = b16_mul(a[7:4], b[7:4]);
    h  = hh ^ b16_mul(a[7:4], b[3:0]) ^ b16_mul(a[3:0], b[7:4]);
    l  = b16_mul(hh, lam) ^ b16_mul(a[3:0], b[3:0]);
    return {h, l};
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // Standard byte -> tower representation (Horner in the root)
  function automatic logic [7:0] front(input logic [7:0] x);
    logic [7:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--)
      r = t_mul(r, root) ^ {7'b0, x[i]};
    return r;
  endfunction

  function automatic logic [7:0] mk_z(input logic [7:0] a,
                                      input logic inv);
    logic [7:0] b;
    logic [7:0] x;
    b = a ^ 8'h63;
    x = inv ? (rotl(b, 1) ^ rotl(b, 3) ^ rotl(b, 6)) : a;
    return tinv[front(x)];
  endfunction

  function automatic exp_t mk_e(input logic [7:0] a, input logic inv);
    exp_t e;
    e.s   = inv ? isbox[a] : sbox[a];
    e.inv = inv;
    return e;
  endfunction

  task automatic setup();
    logic [15:0] hit;
    logic [8:0]  poly;
    logic [7:0]  r;
    logic [7:0]  x;
    bit          found;
    hit = '0;
    for (int w = 0; w < 16; w++)
      hit[4'(b16_mul(4'(w), 4'(w)) ^ 4'(w))] = 1'b1;
    found = 0;
    lam   = '0;
    for (int c = 0; c < 16; c++)
      if (!found && !hit[c]) begin lam = 4'(c); found = 1; end
    poly  = 9'h11B;
    found = 0;
    root  = '0;
    for (int c = 2; c < 256; c++) begin
      r = '0;
      for (int d = 8; d >= 0; d--)
        r = t_mul(r, 8'(c)) ^ {7'b0, poly[d]};
      if (!found && r == 8'h00) begin root = 8'(c); found = 1; end
    end
    for (int a = 0; a < 256; a++) begin
      x = 8'h01;
      r = 8'h01;
      for (int k = 0; k < 254; k++) begin
        x = aes_mul(x, 8'(a));
        r = t_mul(r, 8'(a));
      end
      tinv[a] = r;
      sbox[a] = x ^ rotl(x, 1) ^ rotl(x, 2) ^ rotl(x, 3)
                  ^ rotl(x, 4) ^ 8'h63;
    end
    for (int a = 0; a < 256; a++) isbox[sbox[a]] = 8'(a);
  endtask

  task automatic step(input logic iv, input logic [7:0] z,
                      input logic inv, input exp_t e,
                      input logic ordy, output logic acc);
    logic of;
    @(negedge clk);
    in_valid  = iv;
    in_z      = z;
    in_inv    = inv;
    out_ready = ordy;
    #1;
    sm_rdy = in_ready;
    sm_ov  = out_valid;
    sm_os  = out_s;
    sm_cnt = out_count;
    if (in_rst_n) chk("count", out_count, q.size());
    if (out_valid) begin
      if (q.size() == 0) chk("extra_beat", out_valid, 1'b0);
      else begin
        chk("out_s", out_s, q[0].s);
        chk("out_inv", out_inv, q[0].inv);
      end
    end else begin
      chk("idle_out", {out_inv, out_s}, 9'h000);
    end
    acc = iv && in_ready;
    of  = out_valid && ordy;
    @(posedge clk);
    if (!in_rst_n) q.delete();
    else begin
      if (of) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
  endtask

  task automatic drain();
    logic acc;
    exp_t e0;
    e0 = '0;
    for (int k = 0; k < 8 && q.size() != 0; k++)
      step(1'b0, 8'h00, 1'b0, e0, 1'b1, acc);
    chk("drained", q.size(), 0);
  endtask

  initial begin
    vec_t vt[12];
    logic acc;
    logic [7:0] hold;
    exp_t e0;
    int n;
    int cyc;
    logic iv, m, ordy;
    logic [7:0] a;

    vt[0]  = '{8'h00, 1'b0, 8'h63};
    vt[1]  = '{8'h01, 1'b0, 8'h7C};
    vt[2]  = '{8'h02, 1'b0, 8'h77};
    vt[3]  = '{8'h10, 1'b0, 8'hCA};
    vt[4]  = '{8'h53, 1'b0, 8'hED};
    vt[5]  = '{8'hFF, 1'b0, 8'h16};
    vt[6]  = '{8'h63, 1'b1, 8'h00};
    vt[7]  = '{8'h7C, 1'b1, 8'h01};
    vt[8]  = '{8'h77, 1'b1, 8'h02};
    vt[9]  = '{8'hCA, 1'b1, 8'h10};
    vt[10] = '{8'hED, 1'b1, 8'h53};
    vt[11] = '{8'h16, 1'b1, 8'hFF};

    n_chk = 0;
    n_pass = 0;
    e0 = '0;
    in_rst_n = 1'b0;
    in_valid = 1'b0;
    in_z = 8'h00;
    in_inv = 1'b0;
    out_ready = 1'b0;
    setup();

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_s", out_s, 8'h00);
    chk("rst_inv", out_inv, 1'b0);
    chk("rst_count", out_count, 2'd0);
    chk("rst_ready", in_ready, 1'b0);
    in_rst_n = 1'b1;
    #1;
    chk("rel_ready", in_ready, 1'b1);

    for (int i = 0; i < 12; i++) begin
      step(1'b1, mk_z(vt[i].a, vt[i].inv), vt[i].inv,
           '{vt[i].exp, vt[i].inv}, 1'b1, acc);
      chk("tbl_acc", acc, 1'b1);
    end
    drain();

    step(1'b1, mk_z(8'h53, 1'b0), 1'b0, mk_e(8'h53, 1'b0), 1'b1, acc);
    for (int k = 1; k <= NS + 1; k++) begin
      step(1'b0, 8'h00, 1'b0, e0, 1'b1, acc);
      chk("lat_valid", sm_ov, k == NS);
    end
    drain();

    for (int i = 0; i < 256; i++)
      step(1'b1, mk_z(8'(i), 1'b0), 1'b0, mk_e(8'(i), 1'b0), 1'b1, acc);
    drain();
    for (int i = 0; i < 256; i++)
      step(1'b1, mk_z(8'(i), 1'b1), 1'b1, mk_e(8'(i), 1'b1), 1'b1, acc);
    drain();
    for (int i = 0; i < 512; i++) begin
      a = 8'(i * 7);
      m = 1'(i);
      step(1'b1, mk_z(a, m), m, mk_e(a, m), 1'b1, acc);
    end
    drain();

    hold = 8'h00;
    for (int k = 0; k < NS + 2; k++) begin
      a = 8'(8'h20 + k);
      step(1'b1, mk_z(a, 1'b0), 1'b0, mk_e(a, 1'b0), 1'b0, acc);
      if (k == NS) begin
        chk("full_ready", sm_rdy, 1'b0);
        chk("full_count", sm_cnt, NS);
        hold = sm_os;
      end
      if (k == NS + 1) begin
        chk("full_ready2", sm_rdy, 1'b0);
        chk("stall_hold", sm_os, hold);
      end
    end
    for (int k = 0; k < 6; k++) begin
      a = 8'(8'h40 + k);
      m = 1'(k);
      step(1'b1, mk_z(a, m), m, mk_e(a, m), 1'b1, acc);
      chk("tput_acc", acc, 1'b1);
      chk("tput_count", sm_cnt, NS);
    end
    drain();

    n = 0;
    cyc = 0;
    while (n < 10000 && cyc < 60000) begin
      iv = 1'($urandom_range(0, 1));
      ordy = 1'($urandom_range(0, 1));
      m = 1'($urandom_range(0, 1));
      a = 8'($urandom_range(0, 255));
      step(iv, mk_z(a, m), m, mk_e(a, m), ordy, acc);
      if (acc) n++;
      cyc++;
    end
    chk("rand_beats", n, 10000);
    drain();

    step(1'b1, mk_z(8'h11, 1'b0), 1'b0, mk_e(8'h11, 1'b0), 1'b0, acc);
    step(1'b1, mk_z(8'h22, 1'b1), 1'b1, mk_e(8'h22, 1'b1), 1'b0, acc);
    @(negedge clk);
    in_rst_n = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("pre_rst_count", out_count, 2'd2);
    chk("in_rst_ready", in_ready, 1'b0);
    @(posedge clk);
    q.delete();
    @(negedge clk);
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_count", out_count, 2'd0);
    chk("mid_rst_s", out_s, 8'h00);
    in_rst_n = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("mid_rel_ready", in_ready, 1'b1);
    for (int k = 0; k < 4; k++) step(1'b0, 8'h00, 1'b0, e0, 1'b1, acc);
    step(1'b1, mk_z(8'h9A, 1'b0), 1'b0, mk_e(8'h9A, 1'b0), 1'b1, acc);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
